// File: rtl/ixu_pkg.sv
// Shared types for the IXU decode stage: op encoding, RV32I opcodes and the per-lane decode record.
package ixu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_XOR   = 4'h2,
        OP_OR    = 4'h3,
        OP_AND   = 4'h4,
        OP_SLL   = 4'h5,
        OP_SRL   = 4'h6,
        OP_SRA   = 4'h7,
        OP_SLT   = 4'h8,
        OP_SLTU  = 4'h9,
        OP_LUI   = 4'hA,
        OP_AUIPC = 4'hB
    } ixu_op_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        ixu_op_e     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [19:0] imm;
        logic        is_imm;
        logic        is_nop;
        logic        illegal;
    } ixu_dec_t;

    // funct3 selects the ALU op; alt picks SUB/SRA (funct7 = 0x20) on the shared encodings.
    function automatic ixu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        ixu_op_e op;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ixu_decode_lane.sv
// Combinational decode of one RV32I ALU/U-type word into an ixu_dec_t record.
module ixu_decode_lane
    import ixu_pkg::*;
(
    input  logic [31:0] inst,
    output ixu_dec_t    dec
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;
    logic       ok;
    logic       alt;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];

    always_comb begin
        dec = '0;
        ok  = 1'b0;
        alt = 1'b0;
        case (opcode)
            OPC_R: begin
                alt     = (f7 == 7'h20);
                ok      = (f7 == 7'h00) || (alt && (f3 == 3'b000 || f3 == 3'b101));
                dec.op  = f3_to_op(f3, alt);
                dec.rs1 = rs1;
                dec.rs2 = rs2;
                dec.rd  = rd;
            end
            OPC_I: begin
                // Only the shift-immediates constrain the upper bits; there is no SUBI.
                alt = (f3 == 3'b101) && (f7 == 7'h20);
                if (f3 == 3'b001)      ok = (f7 == 7'h00);
                else if (f3 == 3'b101) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else                   ok = 1'b1;
                dec.op     = f3_to_op(f3, alt);
                dec.rs1    = rs1;
                dec.rd     = rd;
                dec.imm    = {{8{inst[31]}}, inst[31:20]};
                dec.is_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ok         = 1'b1;
                dec.op     = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.rd     = rd;
                dec.imm    = inst[31:12];
                dec.is_imm = 1'b1;
            end
            default: ok = 1'b0;
        endcase

        if (inst == 32'h0000_0000 || inst == 32'h0000_0013) begin
            dec        = '0;
            dec.is_nop = 1'b1;
        end else if (!ok) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ixu_decode_stage.sv
// Registered multi-lane IXU decode stage: per-lane decode, intra-bundle RAW detection,
// output register plus skid entry, and a saturating illegal-lane counter.
module ixu_decode_stage
    import ixu_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_LANES*32-1:0] in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_LANES*4-1:0]  out_op,
    output logic [NUM_LANES*5-1:0]  out_rs1,
    output logic [NUM_LANES*5-1:0]  out_rs2,
    output logic [NUM_LANES*5-1:0]  out_rd,
    output logic [NUM_LANES*20-1:0] out_imm,
    output logic [NUM_LANES-1:0]    out_is_imm,
    output logic [NUM_LANES-1:0]    out_is_nop,
    output logic [NUM_LANES-1:0]    out_illegal,
    output logic [NUM_LANES-1:0]    out_raw_dep,
    output logic [ILL_CNT_W-1:0]    ill_count
);

    // Handshake: a bundle moves on a side only in a cycle where valid && ready at the
    // rising edge; in_ready comes straight from the skid flag, never from out_ready.
    ixu_dec_t             dec    [NUM_LANES];
    ixu_dec_t             out_q  [NUM_LANES];
    ixu_dec_t             skid_q [NUM_LANES];
    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] out_raw_q;
    logic [NUM_LANES-1:0] skid_raw_q;
    logic                 out_valid_q;
    logic                 skid_valid_q;
    logic                 accept;
    logic [3:0]           ill_pop;
    logic [ILL_CNT_W+3:0] ill_sum;
    logic [ILL_CNT_W-1:0] ill_count_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ixu_decode_lane u_lane (
            .inst (in_inst[32*g +: 32]),
            .dec  (dec[g])
        );
        assign out_op[4*g +: 4]    = out_q[g].op;
        assign out_rs1[5*g +: 5]   = out_q[g].rs1;
        assign out_rs2[5*g +: 5]   = out_q[g].rs2;
        assign out_rd[5*g +: 5]    = out_q[g].rd;
        assign out_imm[20*g +: 20] = out_q[g].imm;
        assign out_is_imm[g]       = out_q[g].is_imm;
        assign out_is_nop[g]       = out_q[g].is_nop;
        assign out_illegal[g]      = out_q[g].illegal;
    end

    // A lane depends on an earlier one when it reads a nonzero rd that lane writes.
    always_comb begin
        raw = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                if (!dec[i].illegal && !dec[i].is_nop && dec[i].rd != 5'd0 &&
                    (dec[j].rs1 == dec[i].rd || (!dec[j].is_imm && dec[j].rs2 == dec[i].rd)))
                    raw[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ill_pop = '0;
        for (int i = 0; i < NUM_LANES; i++)
            ill_pop = ill_pop + 4'(dec[i].illegal);
        ill_sum = {4'b0, ill_count_q} + (ILL_CNT_W+4)'(ill_pop);
    end

    assign in_ready    = !skid_valid_q;
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_raw_dep = out_raw_q;
    assign ill_count   = ill_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_raw_q    <= '0;
            skid_raw_q   <= '0;
            ill_count_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                out_q[i]  <= '0;
                skid_q[i] <= '0;
            end
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                if (ill_sum > {4'b0, {ILL_CNT_W{1'b1}}}) ill_count_q <= '1;
                else                                      ill_count_q <= ill_sum[ILL_CNT_W-1:0];
            end
            if (!out_valid_q || out_ready) begin
                // Skid is older than anything at the input, and in_ready is low while it is full.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_raw_q    <= skid_raw_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= dec;
                    out_raw_q   <= raw;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q       <= dec;
                skid_raw_q   <= raw;
                skid_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ixu_decode_stage.sv
// Directed bench for ixu_decode_stage (2 lanes): expected bundles queued at acceptance,
// compared in order when the stage emits them.
module tb_ixu_decode_stage;

  localparam int LANES = 2;
  localparam int LW = 43;
  localparam int BW = LW * LANES;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*32-1:0]    in_inst;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*4-1:0]     out_op;
  logic [LANES*5-1:0]     out_rs1;
  logic [LANES*5-1:0]     out_rs2;
  logic [LANES*5-1:0]     out_rd;
  logic [LANES*20-1:0]    out_imm;
  logic [LANES-1:0]       out_is_imm;
  logic [LANES-1:0]       out_is_nop;
  logic [LANES-1:0]       out_illegal;
  logic [LANES-1:0]       out_raw_dep;
  logic [7:0]             ill_count;

  logic [BW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  ixu_decode_stage #(.NUM_LANES(LANES), .ILL_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_is_imm  (out_is_imm),
    .out_is_nop  (out_is_nop),
    .out_illegal (out_illegal),
    .out_raw_dep (out_raw_dep),
    .ill_count   (ill_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] lane_exp(input logic [3:0] op, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [4:0] rd, input logic [19:0] imm,
      input logic is_imm, input logic nop, input logic ill, input logic raw);
    return {raw, ill, nop, is_imm, imm, rd, rs2, rs1, op};
  endfunction

  function automatic logic [BW-1:0] get_obs();
    logic [BW-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[LW*i +: LW] = {out_raw_dep[i], out_illegal[i], out_is_nop[i], out_is_imm[i],
                       out_imm[20*i +: 20], out_rd[5*i +: 5], out_rs2[5*i +: 5],
                       out_rs1[5*i +: 5], out_op[4*i +: 4]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: scoreboard check at the falling edge, then step to 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", get_obs(), '0);
        if (get_obs() == '0) begin
          n_err++;
          $error("FAIL unexpected_output: observed out_valid=1 expected out_valid=0");
        end
      end else begin
        chk("bundle", get_obs(), exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver: hold the bundle until accepted; its expectation is queued at the accepting edge
  task automatic drive(input logic [63:0] inst, input logic [BW-1:0] exp);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_inst = inst;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", BW'(in_ready), BW'(1));
    end else begin
      exp_q.push_back(exp);
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [BW-1:0] e_t1, e_t2, e_t3, e_ill, e_a, e_b, e_c;
  localparam logic [LW-1:0] NOP_L = {1'b0, 1'b0, 1'b1, 1'b0, 20'h0, 5'd0, 5'd0, 5'd0, 4'h0};
  localparam logic [LW-1:0] ILL_L = {1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 5'd0, 5'd0, 5'd0, 4'h0};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = '0;
    out_ready = 1'b1;

    e_t1 = {lane_exp(4'h1, 5'd1, 5'd2, 5'd2, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0),
            lane_exp(4'h0, 5'd1, 5'd2, 5'd0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0)};
    e_t2 = {lane_exp(4'h0, 5'd1, 5'd1, 5'd2, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1),
            lane_exp(4'h0, 5'd0, 5'd0, 5'd1, 20'hFFFFF, 1'b1, 1'b0, 1'b0, 1'b0)};
    e_t3 = {NOP_L, lane_exp(4'hA, 5'd0, 5'd0, 5'd1, 20'h12345, 1'b1, 1'b0, 1'b0, 1'b0)};
    e_ill = {ILL_L, ILL_L};
    e_a = {NOP_L, lane_exp(4'h0, 5'd0, 5'd0, 5'd3, 20'h00005, 1'b1, 1'b0, 1'b0, 1'b0)};
    e_b = {NOP_L, lane_exp(4'h0, 5'd0, 5'd0, 5'd4, 20'h0000A, 1'b1, 1'b0, 1'b0, 1'b0)};
    e_c = {NOP_L, lane_exp(4'h0, 5'd0, 5'd0, 5'd5, 20'h0000F, 1'b1, 1'b0, 1'b0, 1'b0)};

    #12;
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_ill_count", BW'(ill_count), BW'(0));
    chk("rst_fields", get_obs(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    drive(64'h40208133_00208033, e_t1);
    chk("latency_1", BW'(out_valid), BW'(1));
    drive(64'h00108133_FFF00093, e_t2);
    drive(64'h00000013_123450B7, e_t3);
    drive(64'h40001033_0000007F, e_ill);
    chk("ill_count_2", BW'(ill_count), BW'(2));
    for (int k = 0; k < 200; k++)
      drive(64'h40001033_0000007F, e_ill);
    for (int k = 0; k < 4; k++) tick();
    chk("ill_count_sat", BW'(ill_count), BW'(8'hFF));
    chk("drain_1", BW'(exp_q.size()), BW'(0));

    // stall: two bundles fit, the third waits
    out_ready = 1'b0;
    drive(64'h00000013_00500193, e_a);
    drive(64'h00000013_00A00213, e_b);
    in_valid = 1'b1;
    in_inst = 64'h00000013_00F00293;
    tick();
    chk("stall_in_ready", BW'(in_ready), BW'(0));
    chk("stall_hold", get_obs(), e_a);
    tick();
    chk("stall_hold_2", get_obs(), e_a);
    out_ready = 1'b1;
    drive(64'h00000013_00F00293, e_c);
    chk("release_valid", BW'(out_valid), BW'(1));
    chk("release_q", BW'(exp_q.size()), BW'(1));
    tick();
    chk("drain_2", BW'(exp_q.size()), BW'(0));

    // flush with both entries full and a bundle on the input
    out_ready = 1'b0;
    drive(64'h00000013_00500193, e_a);
    drive(64'h00000013_00A00213, e_b);
    chk("full_in_ready", BW'(in_ready), BW'(0));
    in_valid = 1'b1;
    in_inst = 64'h00000013_00F00293;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", BW'(out_valid), BW'(0));
    chk("flush_in_ready", BW'(in_ready), BW'(1));
    chk("flush_ill_count", BW'(ill_count), BW'(8'hFF));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_flush_idle", BW'(out_valid), BW'(0));
    end

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(64'h00000013_00500193, e_a);
    drive(64'h00000013_00A00213, e_b);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_out_valid", BW'(out_valid), BW'(0));
    chk("arst_in_ready", BW'(in_ready), BW'(1));
    chk("arst_fields", get_obs(), '0);
    chk("arst_ill_count", BW'(ill_count), BW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // flush drops an input that would otherwise be accepted, counter untouched
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_inst = 64'h40001033_0000007F;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_valid", BW'(out_valid), BW'(0));
    chk("flush_drop_count", BW'(ill_count), BW'(0));
    tick();

    // back-to-back throughput
    drive(64'h40208133_00208033, e_t1);
    drive(64'h00108133_FFF00093, e_t2);
    drive(64'h00000013_123450B7, e_t3);
    drive(64'h00000013_00500193, e_a);
    chk("burst_depth", BW'(exp_q.size()), BW'(1));
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    chk("drain_3", BW'(exp_q.size()), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
